// File: rtl/bus8_ac_event_timer.sv
// Bus-programmable event timer: each channel times a start level from the autoclear
// block and returns a one-cycle done pulse, or records an abort if the start drops early.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a rising edge on i_AC_Start[ch]
//   ST_RUN  | counting CNT[ch] down on prescale ticks toward done
module bus8_ac_event_timer #(
   parameter int NUM_CH = 2
) (
   input  logic              i_Bus_Clk,
   input  logic              i_Bus_Rst_L,
   input  logic              i_Bus_CS,
   input  logic              i_Bus_Wr_Rd_n,
   input  logic [2:0]        i_Bus_Addr8,
   input  logic [7:0]        i_Bus_Wr_Data,
   output logic [7:0]        o_Bus_Rd_Data,
   output logic              o_Bus_Rd_DV,
   input  logic [NUM_CH-1:0] i_AC_Start,
   output logic [NUM_CH-1:0] o_AC_Done
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   logic [7:0]        r_Dur [NUM_CH];
   logic [7:0]        r_Prescale;
   logic [7:0]        r_Presc_Cnt;
   logic [NUM_CH-1:0] r_Abort_Hist;
   logic [NUM_CH-1:0] r_Start_Q;
   logic [7:0]        r_Rd_Data;
   logic              r_Rd_DV;

   logic [NUM_CH-1:0] w_Run;
   logic [NUM_CH-1:0] w_Done;
   logic [NUM_CH-1:0] w_Abort_Set;
   logic              w_Wr;
   logic              w_Rd;
   logic              w_Presc_Wr;
   logic              w_Hist_Clr;
   logic              w_Tick;
   logic [7:0]        w_Run8;
   logic [7:0]        w_Hist8;
   logic [7:0]        w_Rd_Mux;

   assign w_Wr       = i_Bus_CS & i_Bus_Wr_Rd_n;
   assign w_Rd       = i_Bus_CS & ~i_Bus_Wr_Rd_n;
   assign w_Presc_Wr = w_Wr && (i_Bus_Addr8 == 3'd5);
   assign w_Hist_Clr = w_Rd && (i_Bus_Addr8 == 3'd6);
   assign w_Tick     = (r_Presc_Cnt == r_Prescale);

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         for (int i = 0; i < NUM_CH; i++) r_Dur[i] <= '0;
         r_Prescale <= '0;
      end else if (w_Wr) begin
         for (int i = 0; i < NUM_CH; i++)
            if (i_Bus_Addr8 == 3'(i)) r_Dur[i] <= i_Bus_Wr_Data;
         if (i_Bus_Addr8 == 3'd5) r_Prescale <= i_Bus_Wr_Data;
      end
   end

   // A PRESCALE write realigns the tick phase to the write.
   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L)    r_Presc_Cnt <= '0;
      else if (w_Presc_Wr) r_Presc_Cnt <= '0;
      else if (w_Tick)     r_Presc_Cnt <= '0;
      else                 r_Presc_Cnt <= r_Presc_Cnt + 8'd1;
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         r_Start_Q    <= '0;
         r_Abort_Hist <= '0;
      end else begin
         r_Start_Q    <= i_AC_Start;
         r_Abort_Hist <= (w_Hist_Clr ? '0 : r_Abort_Hist) | w_Abort_Set;
      end
   end

   always_comb begin
      w_Run8                = '0;
      w_Run8[NUM_CH-1:0]    = w_Run;
      w_Hist8               = '0;
      w_Hist8[NUM_CH-1:0]   = r_Abort_Hist;
      w_Rd_Mux              = '0;
      case (i_Bus_Addr8)
         3'd4:    w_Rd_Mux = w_Run8;
         3'd5:    w_Rd_Mux = r_Prescale;
         3'd6:    w_Rd_Mux = w_Hist8;
         default: begin
            for (int i = 0; i < NUM_CH; i++)
               if (i_Bus_Addr8 == 3'(i)) w_Rd_Mux = r_Dur[i];
         end
      endcase
   end

   always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
      if (!i_Bus_Rst_L) begin
         r_Rd_DV   <= 1'b0;
         r_Rd_Data <= '0;
      end else begin
         r_Rd_DV   <= w_Rd;
         r_Rd_Data <= w_Rd ? w_Rd_Mux : 8'h00;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t     r_State;
      state_t     w_State_Nxt;
      logic [7:0] r_Cnt;
      logic [7:0] w_Cnt_Nxt;
      logic       r_Done;
      logic       w_Done_Nxt;
      logic       w_Abort;
      logic       w_Rise;
      logic       w_Fall;

      assign w_Rise = i_AC_Start[g] & ~r_Start_Q[g];
      assign w_Fall = ~i_AC_Start[g] & r_Start_Q[g];

      always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
         if (!i_Bus_Rst_L) begin
            r_State <= ST_IDLE;
            r_Cnt   <= '0;
            r_Done  <= 1'b0;
         end else begin
            r_State <= w_State_Nxt;
            r_Cnt   <= w_Cnt_Nxt;
            r_Done  <= w_Done_Nxt;
         end
      end

      // Abort is checked before the terminal count so a simultaneous stop suppresses done.
      always_comb begin
         w_State_Nxt = r_State;
         w_Cnt_Nxt   = r_Cnt;
         w_Done_Nxt  = 1'b0;
         w_Abort     = 1'b0;
         case (r_State)
            ST_IDLE: begin
               if (w_Rise) begin
                  if (r_Dur[g] != 8'd0) begin
                     w_Cnt_Nxt   = r_Dur[g];
                     w_State_Nxt = ST_RUN;
                  end else begin
                     w_Done_Nxt  = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_Fall) begin
                  w_Abort     = 1'b1;
                  w_State_Nxt = ST_IDLE;
               end else if (w_Tick) begin
                  w_Cnt_Nxt = r_Cnt - 8'd1;
                  if (r_Cnt == 8'd1) begin
                     w_Done_Nxt  = 1'b1;
                     w_State_Nxt = ST_IDLE;
                  end
               end
            end
            default: w_State_Nxt = ST_IDLE;
         endcase
      end

      assign w_Run[g]       = (r_State == ST_RUN);
      assign w_Done[g]      = r_Done;
      assign w_Abort_Set[g] = w_Abort;
   end

   assign o_AC_Done     = w_Done;
   assign o_Bus_Rd_Data = r_Rd_Data;
   assign o_Bus_Rd_DV   = r_Rd_DV;

endmodule

// File: tb/tb_bus8_ac_event_timer.sv
// Directed bench for bus8_ac_event_timer: a register-access vector table followed by
// hand-written timing sequences for run, abort, zero duration and reset.
module tb_bus8_ac_event_timer;
   localparam int NUM_CH = 2;

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   logic              clk   = 1'b0;
   logic              rst_l = 1'b0;
   logic              cs    = 1'b0;
   logic              wr    = 1'b0;
   logic [2:0]        addr  = '0;
   logic [7:0]        wdata = '0;
   logic [7:0]        rd_data;
   logic              rd_dv;
   logic [NUM_CH-1:0] start = '0;
   logic [NUM_CH-1:0] done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_high   [NUM_CH] = '{default: 0};
   int n_pulse  [NUM_CH] = '{default: 0};
   int rise_cyc [NUM_CH] = '{default: 0};
   logic [NUM_CH-1:0] prev_done = '0;

   bus8_ac_event_timer #(.NUM_CH(NUM_CH)) dut (
      .i_Bus_Clk     (clk),
      .i_Bus_Rst_L   (rst_l),
      .i_Bus_CS      (cs),
      .i_Bus_Wr_Rd_n (wr),
      .i_Bus_Addr8   (addr),
      .i_Bus_Wr_Data (wdata),
      .o_Bus_Rd_Data (rd_data),
      .o_Bus_Rd_DV   (rd_dv),
      .i_AC_Start    (start),
      .o_AC_Done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Done monitor: counts high samples, pulses and the cycle of each pulse's start.
   always @(negedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (done[c]) begin
            n_high[c] <= n_high[c] + 1;
            if (!prev_done[c]) begin
               n_pulse[c]  <= n_pulse[c] + 1;
               rise_cyc[c] <= cyc;
            end
         end
      end
      prev_done <= done;
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_range(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk); cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic v);
      @(negedge clk); cs = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk); d = rd_data; v = rd_dv; cs = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       v;
      bus_read(a, d, v);
      check({nm, " data"}, int'(d), int'(exp));
      check({nm, " dv"}, int'(v), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [20];
      int         c0;
      int         p0, p1, h0, h1;
      logic [7:0] d;

      vecs[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 3'd5, 8'h00, 8'h00};
      vecs[2]  = '{1'b1, 3'd0, 8'hA5, 8'h00};
      vecs[3]  = '{1'b0, 3'd0, 8'h00, 8'hA5};
      vecs[4]  = '{1'b1, 3'd1, 8'h3C, 8'h00};
      vecs[5]  = '{1'b0, 3'd1, 8'h00, 8'h3C};
      vecs[6]  = '{1'b0, 3'd0, 8'h00, 8'hA5};
      vecs[7]  = '{1'b1, 3'd2, 8'h77, 8'h00};
      vecs[8]  = '{1'b0, 3'd2, 8'h00, 8'h00};
      vecs[9]  = '{1'b1, 3'd3, 8'h11, 8'h00};
      vecs[10] = '{1'b0, 3'd3, 8'h00, 8'h00};
      vecs[11] = '{1'b1, 3'd5, 8'h0F, 8'h00};
      vecs[12] = '{1'b0, 3'd5, 8'h00, 8'h0F};
      vecs[13] = '{1'b1, 3'd7, 8'hFF, 8'h00};
      vecs[14] = '{1'b0, 3'd7, 8'h00, 8'h00};
      vecs[15] = '{1'b1, 3'd6, 8'hFF, 8'h00};
      vecs[16] = '{1'b0, 3'd6, 8'h00, 8'h00};
      vecs[17] = '{1'b0, 3'd4, 8'h00, 8'h00};
      vecs[18] = '{1'b1, 3'd5, 8'h00, 8'h00};
      vecs[19] = '{1'b0, 3'd5, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      check("reset done", int'(done), 0);
      check("reset dv", int'(rd_dv), 0);
      check("reset data", int'(rd_data), 0);
      rst_l = 1'b1;

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
         else            read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Basic run, with a DUR rewrite mid-run that must not disturb the count
      bus_write(3'd5, 8'd0);
      bus_write(3'd0, 8'd5);
      @(negedge clk); start[0] = 1'b1; c0 = cyc; p0 = n_pulse[0]; h0 = n_high[0];
      read_chk("run0 status", 3'd4, 8'h01);
      bus_write(3'd0, 8'd100);
      repeat (10) @(negedge clk);
      check("run0 pulses", n_pulse[0] - p0, 1);
      check("run0 width", n_high[0] - h0, 1);
      check_range("run0 latency", rise_cyc[0] - c0, 5, 6);
      read_chk("run0 idle", 3'd4, 8'h00);
      read_chk("run0 dur kept", 3'd0, 8'd100);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);

      // Prescaled run on channel 1
      bus_write(3'd5, 8'd3);
      bus_write(3'd1, 8'd2);
      @(negedge clk); start[1] = 1'b1; c0 = cyc;
      p0 = n_pulse[0]; p1 = n_pulse[1]; h1 = n_high[1];
      read_chk("presc run a", 3'd4, 8'h02);
      read_chk("presc run b", 3'd4, 8'h02);
      repeat (14) @(negedge clk);
      check("presc pulses", n_pulse[1] - p1, 1);
      check("presc width", n_high[1] - h1, 1);
      check_range("presc latency", rise_cyc[1] - c0, 4, 12);
      check("presc ch0 quiet", n_pulse[0] - p0, 0);
      read_chk("presc idle", 3'd4, 8'h00);
      start[1] = 1'b0;
      repeat (2) @(negedge clk);

      // Software stop mid-run
      bus_write(3'd5, 8'd0);
      bus_write(3'd0, 8'd10);
      @(negedge clk); start[0] = 1'b1; p0 = n_pulse[0];
      repeat (3) @(negedge clk);
      start[0] = 1'b0;
      repeat (15) @(negedge clk);
      check("abort no done", n_pulse[0] - p0, 0);
      read_chk("abort run", 3'd4, 8'h00);
      read_chk("abort hist 1st", 3'd6, 8'h01);
      read_chk("abort hist 2nd", 3'd6, 8'h00);

      // Stop on the same edge as the terminal count: abort wins
      bus_write(3'd0, 8'd3);
      @(negedge clk); start[0] = 1'b1; p0 = n_pulse[0];
      repeat (3) @(negedge clk);
      start[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("abort@tc no done", n_pulse[0] - p0, 0);
      read_chk("abort@tc hist", 3'd6, 8'h01);

      // Abort set coinciding with a history read-clear: set survives
      bus_write(3'd0, 8'd10);
      @(negedge clk); start[0] = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk); cs = 1'b1; wr = 1'b0; addr = 3'd6; start[0] = 1'b0;
      @(negedge clk); d = rd_data; cs = 1'b0;
      check("setwins old value", int'(d), 0);
      read_chk("setwins hist", 3'd6, 8'h01);
      read_chk("setwins cleared", 3'd6, 8'h00);

      // Zero duration: immediate done, never RUN
      bus_write(3'd0, 8'd0);
      @(negedge clk); start[0] = 1'b1; c0 = cyc; p0 = n_pulse[0]; h0 = n_high[0];
      read_chk("dur0 run", 3'd4, 8'h00);
      repeat (4) @(negedge clk);
      check("dur0 pulses", n_pulse[0] - p0, 1);
      check("dur0 width", n_high[0] - h0, 1);
      check("dur0 latency", rise_cyc[0] - c0, 1);
      read_chk("dur0 run after", 3'd4, 8'h00);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);

      // Reset while both channels run; starts stay high through release
      bus_write(3'd0, 8'd50);
      bus_write(3'd1, 8'd50);
      bus_write(3'd5, 8'd7);
      @(negedge clk); start = 2'b11;
      repeat (3) @(negedge clk);
      read_chk("pre-reset run", 3'd4, 8'h03);
      #2 rst_l = 1'b0;
      #1;
      check("rst done", int'(done), 0);
      check("rst dv", int'(rd_dv), 0);
      check("rst data", int'(rd_data), 0);
      repeat (2) @(negedge clk);
      p0 = n_pulse[0]; p1 = n_pulse[1]; c0 = cyc;
      rst_l = 1'b1;
      repeat (4) @(negedge clk);
      check("restart ch0 pulses", n_pulse[0] - p0, 1);
      check("restart ch1 pulses", n_pulse[1] - p1, 1);
      check("restart ch0 latency", rise_cyc[0] - c0, 1);
      check("restart ch1 latency", rise_cyc[1] - c0, 1);
      read_chk("restart run", 3'd4, 8'h00);
      read_chk("restart dur0", 3'd0, 8'h00);
      read_chk("restart dur1", 3'd1, 8'h00);
      read_chk("restart presc", 3'd5, 8'h00);
      start = 2'b00;
      repeat (2) @(negedge clk);

      // Reserved read, DV width, and RO write to RUN
      read_chk("rsv read", 3'd7, 8'h00);
      @(negedge clk);
      check("dv one cycle", int'(rd_dv), 0);
      bus_write(3'd0, 8'd50);
      @(negedge clk); start[0] = 1'b1;
      read_chk("ro run before", 3'd4, 8'h01);
      bus_write(3'd4, 8'hFE);
      read_chk("ro run after", 3'd4, 8'h01);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      read_chk("ro abort hist", 3'd6, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus8_ac_event_timer.md
BUS8_AC_EVENT_TIMER -- requirements
Module: bus8_ac_event_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, legal range 1..4, giving the number of timed event channels.
REQ-002 The block SHALL have these ports:
- i_Bus_Clk  in  1  bus clock.
- i_Bus_Rst_L  in  1  reset, asynchronous, active-low.
- i_Bus_CS  in  1  bus chip select.
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Bus_Addr8  in  3  register offset.
- i_Bus_Wr_Data  in  8  write data.
- o_Bus_Rd_Data  out  8  read data.
- o_Bus_Rd_DV  out  1  read data valid.
- i_AC_Start  in  NUM_CH  per-channel start levels, driven by the autoclear block's start outputs.
- o_AC_Done  out  NUM_CH  per-channel one-cycle completion pulses, returned to the autoclear block's done inputs.
REQ-003 The clock SHALL be i_Bus_Clk; the reset SHALL be i_Bus_Rst_L, asynchronous, active-low.

Function
REQ-004 Register map:
- 0x0..0x3: DUR[ch], RW, 8 bit, one per channel ch < NUM_CH.
- 0x4: RUN status, RO; bit ch = channel running.
- 0x5: PRESCALE, RW, 8 bit.
- 0x6: ABORT_HIST, RO; a read returns the value and clears it.
- 0x7: reserved.
REQ-005 Write cycle (CS=1, Wr_Rd_n=1): the addressed RW register SHALL update on the same clock edge. Writes to RO, reserved or unused-channel offsets SHALL be ignored.
REQ-006 Read cycle (CS=1, Wr_Rd_n=0): o_Bus_Rd_DV SHALL pulse high for exactly one cycle, on the edge following the request. o_Bus_Rd_Data SHALL be valid in that same cycle. Unmapped offsets, unused channels and unused bits SHALL read 0x00.
REQ-007 A prescale tick SHALL occur once every PRESCALE+1 clocks, from a free-running 8-bit counter.
- The counter restarts from 0 when PRESCALE is written.
- PRESCALE = 0 SHALL produce a tick every clock.
REQ-008 Each channel SHALL register i_AC_Start[ch] and detect edges as current AND NOT previous (rising) and previous AND NOT current (falling).
REQ-009 Each channel SHALL run a state machine with states IDLE and RUN, plus an 8-bit down-counter CNT[ch].
REQ-010 IDLE, rising edge, DUR[ch] != 0: the channel SHALL load CNT[ch] = DUR[ch] and enter RUN on the next edge.
REQ-011 IDLE, rising edge, DUR[ch] = 0: the channel SHALL pulse o_AC_Done[ch] on the next edge and stay IDLE.
REQ-012 RUN, on each prescale tick: CNT[ch] SHALL decrement. When CNT[ch] goes 1 -> 0:
- o_AC_Done[ch] SHALL assert for exactly one cycle.
- The channel SHALL return to IDLE.
- Total latency is DUR[ch] ticks, ±1 tick phase.
REQ-013 RUN, falling edge on i_AC_Start[ch] (software stop): the channel SHALL enter IDLE without a done pulse and set ABORT_HIST[ch].
REQ-014 Simultaneous events:
- Falling edge and terminal count in the same cycle: abort wins; no done pulse.
- ABORT_HIST set and read-clear in the same cycle: set wins.
REQ-015 A write to DUR[ch] while the channel is in RUN SHALL NOT affect CNT[ch]; the new value applies at the next start.
REQ-016 Channels SHALL be fully independent apart from the shared prescale tick.

Reset
REQ-017 Reset assertion SHALL immediately clear the following, mid-operation included:
- all channels to IDLE; CNT, DUR, PRESCALE, ABORT_HIST and the prescale counter to 0;
- the registered start levels to 0;
- o_AC_Done, o_Bus_Rd_DV and o_Bus_Rd_Data to 0.
REQ-018 After reset release, a start input already held high SHALL be treated as a rising edge on the first clock.

Verification
REQ-019 DUR0=5, PRESCALE=0; raise i_AC_Start[0] -> RUN reads 0x01; o_AC_Done[0] is a single-cycle pulse 5–6 clocks after the edge.
REQ-020 PRESCALE=3, DUR1=2; start ch1 -> done pulse 8±4 clocks after the edge; RUN bit 1 = 1 throughout.
REQ-021 DUR0=10; start, then drop i_AC_Start[0] after 3 clocks -> no done pulse; RUN=0x00; first ABORT_HIST read = 0x01, second read = 0x00.
REQ-022 DUR0=0; start -> done pulse on the next clock; RUN stays 0x00.
REQ-023 Assert reset while both channels are in RUN -> all outputs are 0 immediately; after release with starts held high, both channels restart.
REQ-024 Read 0x7 -> data 0x00 with a one-cycle o_Bus_Rd_DV; write 0x4 -> RUN is unchanged.
